// File: rtl/temp_stream_reader.sv
// Streams a contiguous window of an async-read coefficient RAM onto a valid/ready port.
// First beat valid two edges after an accepted start; a stalled beat holds data, address and count.
module temp_stream_reader #(
  parameter int RAM_WIDTH     = 13,
  parameter int RAM_ADDR_BITS = 11,
  parameter int LEN_BITS      = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] base_addr,
  input  logic [LEN_BITS-1:0]      length,
  output logic                     busy,
  output logic                     done,
  output logic [RAM_ADDR_BITS-1:0] read_address,
  input  logic [RAM_WIDTH-1:0]     ram_data,
  output logic [RAM_WIDTH-1:0]     m_data,
  output logic                     m_valid,
  input  logic                     m_ready
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_LAST   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [LEN_BITS-1:0]      rem_q, rem_d;
  logic [RAM_WIDTH-1:0]     data_q, data_d;
  logic                     vld_q, vld_d;
  logic                     load;

  // The output register refills whenever it is empty or its word leaves this cycle.
  assign load = (state_q == S_STREAM) && (!vld_q || m_ready);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    vld_d   = vld_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_d  = base_addr;
            rem_d   = length;
            state_d = S_STREAM;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_STREAM: begin
        if (load) begin
          data_d = ram_data;
          vld_d  = 1'b1;
          addr_d = addr_q + RAM_ADDR_BITS'(1);
          rem_d  = rem_q - LEN_BITS'(1);
          if (rem_q == LEN_BITS'(1)) begin
            state_d = S_LAST;
          end
        end
      end
      S_LAST: begin
        if (m_ready) begin
          vld_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

  assign busy         = (state_q == S_STREAM) || (state_q == S_LAST);
  assign done         = (state_q == S_DONE);
  assign read_address = addr_q;
  assign m_data       = data_q;
  assign m_valid      = vld_q;

endmodule

// File: tb/tb_temp_stream_reader.sv
// Directed bench for temp_stream_reader against a behavioural RAM holding mem[i]=i.
module tb_temp_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] base_addr;
  logic [11:0] length;
  logic        busy;
  logic        done;
  logic [10:0] read_address;
  logic [12:0] ram_data;
  logic [12:0] m_data;
  logic        m_valid;
  logic        m_ready;

  logic [12:0] mem [0:2047];
  assign ram_data = mem[read_address];

  always #5 clk = ~clk;

  temp_stream_reader #(.RAM_WIDTH(13), .RAM_ADDR_BITS(11), .LEN_BITS(12)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .read_address(read_address), .ram_data(ram_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  int total = 0;
  int bad = 0;

  // Observations filled by run_stream; cycle 1 is the cycle after the start edge.
  logic [12:0] cap[$];
  int done_cnt, done_cyc, first_vld, last_beat, busy_hi, stall_bad, vld_seen;
  logic saw_zero, timed_out, injected;

  function automatic logic ready_pat(input int mode, input int k);
    if (mode == 0) return 1'b1;
    case (k % 6)
      0: return 1'b1;
      1: return 1'b0;
      2: return 1'b0;
      3: return 1'b1;
      4: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int data_errs(input int b);
    int n = 0;
    logic [12:0] e;
    for (int i = 0; i < cap.size(); i++) begin
      e = 13'((b + i) % 2048);
      if (cap[i] !== e) n++;
    end
    return n;
  endfunction

  task automatic run_stream(input int b, input int len, input int rmode,
                            input int inj_at, input int stop_at, input int budget);
    int k, post;
    logic pv, pr;
    logic [12:0] pd;
    cap.delete();
    done_cnt = 0; done_cyc = -1; first_vld = -1; last_beat = -1; busy_hi = 0;
    stall_bad = 0; vld_seen = 0; saw_zero = 0; timed_out = 0; injected = 0;
    base_addr = 11'(b); length = 12'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1; pv = 0; pr = 0; pd = '0; post = -1;
    while (1) begin
      m_ready = ready_pat(rmode, k);
      if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd)) stall_bad++;
      if (m_valid) begin vld_seen++; if (first_vld < 0) first_vld = k; end
      if (busy) busy_hi++;
      if (busy && read_address == 11'd0) saw_zero = 1;
      if (done) begin done_cnt++; done_cyc = k; if (post < 0) post = 3; end
      if (m_valid && m_ready) begin cap.push_back(m_data); last_beat = k; end
      if (inj_at > 0 && !injected && cap.size() == inj_at) begin
        injected = 1; start = 1'b1; base_addr = 11'd900; length = 12'd3;
      end
      pv = m_valid; pr = m_ready; pd = m_data;
      @(posedge clk); #1;
      start = 1'b0;
      if (stop_at > 0 && cap.size() == stop_at) break;
      if (post == 0) break;
      if (post > 0) post--;
      k++;
      if (k > budget) begin timed_out = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", m_valid); end
    total++; if (m_data !== 13'd0) begin bad++; $display("FAIL reset_data got=%0d want=0", m_data); end
    total++; if (read_address !== 11'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", read_address); end
    // A start coinciding with reset must not launch a transfer.
    start = 1'b1; length = 12'd4; base_addr = 11'd7;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_start_ignored busy=%0b done=%0b want 0/0", busy, done); end
  endtask

  task automatic test_basic;
    run_stream(0, 757, 0, 0, 0, 900);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%0b want=0", timed_out); end
    total++; if (cap.size() !== 757) begin bad++; $display("FAIL basic_count got=%0d want=757", cap.size()); end
    total++; if (data_errs(0) !== 0) begin bad++; $display("FAIL basic_data errs=%0d want=0", data_errs(0)); end
    total++; if (first_vld !== 2) begin bad++; $display("FAIL basic_first_valid got=%0d want=2", first_vld); end
    total++; if (last_beat !== 758) begin bad++; $display("FAIL basic_last_beat got=%0d want=758", last_beat); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", done_cnt); end
    total++; if (done_cyc !== 759) begin bad++; $display("FAIL basic_done_cycle got=%0d want=759", done_cyc); end
    total++; if (busy_hi !== 758) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=758", busy_hi); end
  endtask

  task automatic test_wrap;
    run_stream(2045, 5, 0, 0, 0, 50);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL wrap_timeout got=%0b want=0", timed_out); end
    total++; if (cap.size() !== 5) begin bad++; $display("FAIL wrap_count got=%0d want=5", cap.size()); end
    total++; if (data_errs(2045) !== 0) begin bad++; $display("FAIL wrap_data errs=%0d want=0", data_errs(2045)); end
    total++; if (saw_zero !== 1'b1) begin bad++; $display("FAIL wrap_addr_zero got=%0b want=1", saw_zero); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL wrap_done_count got=%0d want=1", done_cnt); end
    total++; if (done_cyc !== 7) begin bad++; $display("FAIL wrap_done_cycle got=%0d want=7", done_cyc); end
  endtask

  task automatic test_backpressure;
    run_stream(100, 8, 1, 0, 0, 100);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL bp_timeout got=%0b want=0", timed_out); end
    total++; if (cap.size() !== 8) begin bad++; $display("FAIL bp_count got=%0d want=8", cap.size()); end
    total++; if (data_errs(100) !== 0) begin bad++; $display("FAIL bp_data errs=%0d want=0", data_errs(100)); end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL bp_stall_hold got=%0d want=0", stall_bad); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL bp_done_count got=%0d want=1", done_cnt); end
    total++; if (done_cyc !== last_beat + 1) begin bad++; $display("FAIL bp_done_cycle got=%0d want=%0d", done_cyc, last_beat + 1); end
  endtask

  task automatic test_zero_len;
    run_stream(300, 0, 0, 0, 0, 20);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL zero_timeout got=%0b want=0", timed_out); end
    total++; if (vld_seen !== 0) begin bad++; $display("FAIL zero_valid_cycles got=%0d want=0", vld_seen); end
    total++; if (busy_hi !== 0) begin bad++; $display("FAIL zero_busy_cycles got=%0d want=0", busy_hi); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL zero_done_count got=%0d want=1", done_cnt); end
    total++; if (done_cyc !== 1) begin bad++; $display("FAIL zero_done_cycle got=%0d want=1", done_cyc); end
  endtask

  task automatic test_mid_start_and_reset;
    int late_done;
    run_stream(0, 20, 0, 6, 0, 60);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL mid_timeout got=%0b want=0", timed_out); end
    total++; if (cap.size() !== 20) begin bad++; $display("FAIL mid_count got=%0d want=20", cap.size()); end
    total++; if (data_errs(0) !== 0) begin bad++; $display("FAIL mid_data errs=%0d want=0", data_errs(0)); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL mid_done_count got=%0d want=1", done_cnt); end
    run_stream(0, 20, 0, 0, 10, 60);
    total++; if (cap.size() !== 10) begin bad++; $display("FAIL abort_beats got=%0d want=10", cap.size()); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_outputs valid=%0b busy=%0b done=%0b want 0/0/0", m_valid, busy, done); end
    late_done = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) late_done++;
      @(posedge clk); #1;
    end
    total++; if (late_done !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", late_done); end
    run_stream(500, 2, 0, 0, 0, 30);
    total++; if (cap.size() !== 2) begin bad++; $display("FAIL fresh_count got=%0d want=2", cap.size()); end
    total++; if (data_errs(500) !== 0) begin bad++; $display("FAIL fresh_data errs=%0d want=0", data_errs(500)); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL fresh_done_count got=%0d want=1", done_cnt); end
  endtask

  task automatic test_full_sweep;
    run_stream(0, 2048, 0, 0, 0, 2200);
    total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL sweep_timeout got=%0b want=0", timed_out); end
    total++; if (cap.size() !== 2048) begin bad++; $display("FAIL sweep_count got=%0d want=2048", cap.size()); end
    total++; if (data_errs(0) !== 0) begin bad++; $display("FAIL sweep_data errs=%0d want=0", data_errs(0)); end
    total++; if (busy_hi !== 2049) begin bad++; $display("FAIL sweep_busy_cycles got=%0d want=2049", busy_hi); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL sweep_done_count got=%0d want=1", done_cnt); end
    total++; if (done_cyc !== 2050) begin bad++; $display("FAIL sweep_done_cycle got=%0d want=2050", done_cyc); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 13'(i);
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_mid_start_and_reset();
    test_full_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/temp_stream_reader.md
Name: temp_stream_reader

Overview:
- Drains a contiguous window of a 13-bit distributed coefficient RAM (2048 deep, asynchronous read) into a valid/ready stream for downstream NTT/multiplier/encode stages.
- It is the read side of the temp buffers. Writers fill a buffer through its write port; this block walks `read_address`, registers the returned word, and hands it off under backpressure.
- A start/done handshake frames each transfer.

Parameters:
- RAM_WIDTH, 13, coefficient width and stream data width.
- RAM_ADDR_BITS, 11, RAM address width; addresses wrap modulo 2**RAM_ADDR_BITS.
- LEN_BITS, 12, width of the transfer length; must be at least RAM_ADDR_BITS+1 so a full 2048-word sweep is expressible.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- base_addr  input  RAM_ADDR_BITS  first RAM address; latched on accepted start.
- length  input  LEN_BITS  number of words to stream; latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until the final handshake cycle inclusive.
- done  output  1  one-cycle pulse after the final word is accepted, or after a zero-length start.
- read_address  output  RAM_ADDR_BITS  to RAM read port; driven from the internal address register.
- ram_data  input  RAM_WIDTH  RAM asynchronous read data for `read_address`, valid in the same cycle.
- m_data  output  RAM_WIDTH  stream data, registered.
- m_valid  output  1  stream valid, registered.
- m_ready  input  1  downstream ready.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, m_valid=0, m_data=0, read_address=0, remaining=0. Reset mid-transfer aborts immediately with no done pulse; any pending word is discarded.
- Handshake: a beat transfers when m_valid&&m_ready at a rising edge.
  - While m_valid=1 and m_ready=0, m_data and m_valid hold stable.
  - m_valid never drops without a transfer.
- Output register load: "load" = (state==STREAM) && (!m_valid || m_ready).
  - On load: m_data<=ram_data, m_valid<=1, read_address<=read_address+1 (wraps 2047->0), remaining<=remaining-1.
- States:
  - IDLE: done=0.
    - start && length!=0: latch base_addr into read_address and length into remaining; go to STREAM; busy=1 next cycle.
    - start && length==0: go to DONE; no beats.
    - start with rst high is ignored.
  - STREAM: loads per the rule above. When a load occurs with remaining==1, go to LAST.
  - LAST: m_valid=1 holds the final word. On handshake: m_valid<=0, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start in DONE is ignored.
- start is ignored in every state except IDLE.
- Latency: start accepted at edge N gives m_valid=1 with mem[base_addr] after edge N+1.
- Throughput: with m_ready held high, one word per cycle; L words complete in L+1 cycles after start, and done is high in cycle L+2.
- Backpressure at any point stalls the address and remaining count with no skipped or duplicated words.
- Wrap-around: base_addr+length may exceed 2048; addresses wrap to 0.
- length > 2**RAM_ADDR_BITS is legal and re-reads wrapped addresses. No error is flagged.
- The block never writes the RAM. RAM contents changing during a transfer are streamed as read at the load cycle.

Test Plan:
- RAM preloaded mem[i]=i; start base=0, length=757, m_ready=1 -> 757 beats with data 0..756 on consecutive cycles; first m_valid one cycle after start; done pulses once, the cycle after the beat carrying 756.
- base=2045, length=5, m_ready=1 -> data 2045,2046,2047,0,1; read_address wraps to 0; done once.
- base=100, length=8, m_ready toggling 1,0,0,1,0,1,... -> exactly data 100..107 in order; m_data stable during every stall; done only after the 8th accept.
- length=0 start -> no m_valid ever; done high exactly one cycle after start; busy stays 0.
- Mid-transfer (base=0, length=20, after 6 beats): assert start -> ignored, stream continues to 19. Then rst high for 1 cycle after beat 10 of a new transfer -> m_valid, busy, done all 0 next cycle; no done pulse; a fresh start (base=500, length=2) streams 500,501.
- Full sweep base=0, length=2048 -> 2048 beats 0..2047, then done; busy high throughout.
